// File: rtl/sens_avg_filter.sv
// sens_avg_filter: per-channel block averager with frame-aligned snapshot and staleness flags.
//  Channels: 0 = temperature, 1 = humidity, 2 = supply voltage.
//  clk, startn          : clock, async active-low reset
//  frame_alt            : frame strobe level; rising edge takes a snapshot of the averages
//  *_din, *_ok_p        : raw sample word and its 1-cycle valid pulse, per channel
//  temp/humid/power_out : snapshot averages, constant between frame edges
//  stale                : {volt,rh,tmp} no-new-average flags, aligned with the snapshot
//  avg_upd_p            : {volt,rh,tmp} 1-cycle pulse when a new average is registered
module sens_avg_filter #(
    parameter int unsigned AVG_LOG2     = 3,
    parameter int unsigned DW           = 16,
    parameter int unsigned STALE_FRAMES = 4
) (
    input  logic          clk,
    input  logic          startn,
    input  logic          frame_alt,
    input  logic [DW-1:0] tmp_din,
    input  logic          tmp_csum_ok_p,
    input  logic [DW-1:0] rh_din,
    input  logic          rh_csum_ok_p,
    input  logic [DW-1:0] volt_din,
    input  logic          volt_ok_p,
    output logic [DW-1:0] temp_out,
    output logic [DW-1:0] humid_out,
    output logic [DW-1:0] power_out,
    output logic [2:0]    stale,
    output logic [2:0]    avg_upd_p
);

    localparam int unsigned AW = DW + AVG_LOG2;
    localparam int unsigned SW = 4;
    localparam logic [AVG_LOG2-1:0] CNT_LAST  = '1;
    localparam logic [SW-1:0]       STALE_MAX = SW'(STALE_FRAMES);

    logic [DW-1:0] din [3];
    logic [DW-1:0] avg [3];
    logic [2:0]    vld;
    logic          frame_alt_d;
    logic          rise_c;

    assign din[0] = tmp_din;
    assign din[1] = rh_din;
    assign din[2] = volt_din;
    assign vld    = {volt_ok_p, rh_csum_ok_p, tmp_csum_ok_p};
    assign rise_c = frame_alt & ~frame_alt_d;

    // Independent accumulate / average / staleness datapath per channel
    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        logic [AW-1:0]       acc;
        logic [AVG_LOG2-1:0] cnt;
        logic [DW-1:0]       avg_q;
        logic [SW-1:0]       scnt;
        logic                stale_q;
        logic                upd_q;
        logic [AW-1:0]       sum_c;
        logic                done_c;
        logic [SW-1:0]       scnt_inc_c;

        assign sum_c      = acc + AW'(din[ch]);
        assign done_c     = vld[ch] && (cnt == CNT_LAST);
        assign scnt_inc_c = (scnt == STALE_MAX) ? scnt : scnt + 1'b1;

        always_ff @(posedge clk or negedge startn) begin
            if (!startn) begin
                acc     <= '0;
                cnt     <= '0;
                avg_q   <= '0;
                scnt    <= STALE_MAX;
                stale_q <= 1'b1;
                upd_q   <= 1'b0;
            end else begin
                upd_q <= done_c;
                if (vld[ch]) begin
                    if (done_c) begin
                        avg_q <= DW'(sum_c >> AVG_LOG2);
                        acc   <= '0;
                        cnt   <= '0;
                    end else begin
                        acc <= sum_c;
                        cnt <= cnt + 1'b1;
                    end
                end
                // Completion beats a coincident frame edge; the flag still uses the old count
                if (done_c) begin
                    scnt <= '0;
                end else if (rise_c) begin
                    scnt <= scnt_inc_c;
                end
                if (rise_c) begin
                    stale_q <= (scnt_inc_c == STALE_MAX);
                end
            end
        end

        assign avg[ch]       = avg_q;
        assign stale[ch]     = stale_q;
        assign avg_upd_p[ch] = upd_q;
    end

    // Frame edge detect and snapshot of the current (pre-update) averages
    always_ff @(posedge clk or negedge startn) begin
        if (!startn) begin
            frame_alt_d <= 1'b0;
            temp_out    <= '0;
            humid_out   <= '0;
            power_out   <= '0;
        end else begin
            frame_alt_d <= frame_alt;
            if (rise_c) begin
                temp_out  <= avg[0];
                humid_out <= avg[1];
                power_out <= avg[2];
            end
        end
    end

endmodule

// File: tb/tb_sens_avg_filter.sv
// tb_sens_avg_filter: directed self-checking bench for sens_avg_filter (default parameters).
module tb_sens_avg_filter;

    logic        clk = 1'b0;
    logic        startn;
    logic        frame_alt;
    logic [15:0] tmp_din, rh_din, volt_din;
    logic        tmp_csum_ok_p, rh_csum_ok_p, volt_ok_p;
    logic [15:0] temp_out, humid_out, power_out;
    logic [2:0]  stale, avg_upd_p;

    int n_tests = 0;
    int n_fail  = 0;

    sens_avg_filter dut (
        .clk          (clk),
        .startn       (startn),
        .frame_alt    (frame_alt),
        .tmp_din      (tmp_din),
        .tmp_csum_ok_p(tmp_csum_ok_p),
        .rh_din       (rh_din),
        .rh_csum_ok_p (rh_csum_ok_p),
        .volt_din     (volt_din),
        .volt_ok_p    (volt_ok_p),
        .temp_out     (temp_out),
        .humid_out    (humid_out),
        .power_out    (power_out),
        .stale        (stale),
        .avg_upd_p    (avg_upd_p)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int ch, input logic [15:0] v);
        case (ch)
            0: begin tmp_din = v;  tmp_csum_ok_p = 1'b1; end
            1: begin rh_din = v;   rh_csum_ok_p  = 1'b1; end
            default: begin volt_din = v; volt_ok_p = 1'b1; end
        endcase
        tick();
        tmp_csum_ok_p = 1'b0;
        rh_csum_ok_p  = 1'b0;
        volt_ok_p     = 1'b0;
    endtask

    task automatic pulses(input int ch, input int n, input logic [15:0] v);
        for (int i = 0; i < n; i++) pulse(ch, v);
    endtask

    task automatic frame_rise();
        frame_alt = 1'b1;
        tick();
        frame_alt = 1'b0;
        tick();
    endtask

    initial begin
        startn = 1'b0; frame_alt = 1'b0;
        tmp_din = '0; rh_din = '0; volt_din = '0;
        tmp_csum_ok_p = 1'b0; rh_csum_ok_p = 1'b0; volt_ok_p = 1'b0;
        tick(); tick();
        check("rst_temp",  32'(temp_out),  32'h0);
        check("rst_humid", 32'(humid_out), 32'h0);
        check("rst_power", 32'(power_out), 32'h0);
        check("rst_stale", 32'(stale),     32'h7);
        check("rst_upd",   32'(avg_upd_p), 32'h0);
        startn = 1'b1;
        tick();

        // Basic average: 0x100..0x107 -> 0x103
        for (int i = 0; i < 8; i++) pulse(0, 16'(16'h0100 + i));
        check("upd_tmp_1", 32'(avg_upd_p), 32'h1);
        check("temp_prerise", 32'(temp_out), 32'h0);
        tick();
        check("upd_tmp_0", 32'(avg_upd_p), 32'h0);
        frame_rise();
        check("temp_basic",  32'(temp_out), 32'h0103);
        check("stale_basic", 32'(stale),    32'h6);

        // Full-scale humidity, back-to-back
        pulses(1, 8, 16'hFFFF);
        check("upd_rh", 32'(avg_upd_p), 32'h2);
        frame_rise();
        check("humid_max",  32'(humid_out), 32'hFFFF);
        check("temp_held",  32'(temp_out),  32'h0103);
        check("stale_rh",   32'(stale),     32'h4);

        // Truncation: sum 13 -> 1
        pulses(0, 4, 16'h0001);
        pulses(0, 3, 16'h0002);
        pulse(0, 16'h0003);
        frame_rise();
        check("temp_trunc", 32'(temp_out), 32'h0001);

        // Voltage staleness over four idle frames
        pulses(2, 8, 16'h0200);
        frame_rise();
        check("power_200", 32'(power_out), 32'h0200);
        check("stale_v1",  32'(stale),     32'h0);
        frame_rise();
        check("stale_v2",  32'(stale),     32'h2);
        frame_rise();
        check("stale_v3",  32'(stale),     32'h3);
        frame_rise();
        check("stale_v4",  32'(stale),     32'h7);
        check("power_hold", 32'(power_out), 32'h0200);
        pulses(2, 8, 16'h0300);
        frame_rise();
        check("power_300",  32'(power_out), 32'h0300);
        check("stale_vclr", 32'(stale),     32'h3);

        // Completion coincident with a frame edge
        pulses(0, 8, 16'h0050);
        frame_rise();
        check("temp_50", 32'(temp_out), 32'h0050);
        frame_rise();
        frame_rise();
        pulses(0, 7, 16'h0060);
        tmp_din = 16'h0060; tmp_csum_ok_p = 1'b1; frame_alt = 1'b1;
        tick();
        tmp_csum_ok_p = 1'b0; frame_alt = 1'b0;
        check("coinc_temp_old", 32'(temp_out),  32'h0050);
        check("coinc_upd",      32'(avg_upd_p), 32'h1);
        check("coinc_stale",    32'(stale),     32'h7);
        tick();
        frame_alt = 1'b1;
        tick();
        check("coinc_temp_new", 32'(temp_out), 32'h0060);
        check("coinc_stale_clr", 32'(stale),   32'h6);

        // frame_alt held high: no further snapshot
        pulses(0, 8, 16'h0070);
        tick();
        check("held_no_snap", 32'(temp_out), 32'h0060);
        frame_alt = 1'b0;
        tick();
        frame_rise();
        check("held_resnap", 32'(temp_out), 32'h0070);

        // Reset mid-accumulation discards partial sum
        pulses(0, 5, 16'h7000);
        startn = 1'b0;
        #1;
        check("mid_rst_stale", 32'(stale),     32'h7);
        check("mid_rst_temp",  32'(temp_out),  32'h0);
        check("mid_rst_upd",   32'(avg_upd_p), 32'h0);
        tick();
        startn = 1'b1;
        tick();
        pulses(0, 8, 16'h0010);
        frame_rise();
        check("post_rst_temp", 32'(temp_out), 32'h0010);
        check("post_rst_stale", 32'(stale),   32'h6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
